// File: rtl/uart_rx_async.sv
// rtl/uart_rx_async.sv - asynchronous UART receiver with 16x oversampling
//
// Purpose:
//   Recovers start, data (7 or 8 bits, LSB first), optional parity and stop
//   bits from an asynchronous serial line. Each bit is decided by a 2-of-3
//   majority of the synchronized line taken at sample counts 7, 8 and 9 of a
//   16-count bit period. A completed byte is either parked in a holding
//   register (RX_FIFO=0) or pushed out through an active-low write strobe
//   (RX_FIFO=1).
//
// Parameters:
//   RX_FIFO        0 = holding register with rx_rdy/overflow handshake
//                  1 = byte written to an external FIFO via fifo_write_rx
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   baud_clock     one-clk enable at 16x the baud rate
//   rx             serial input, asynchronous, idle high
//   bit8           1 = 8 data bits, 0 = 7 data bits
//   parity_en      parity bit expected after the data bits
//   odd_n_even     1 = odd parity, 0 = even parity
//   read_rx_byte   one-clk pulse: host consumed rx_byte (clears rx_rdy, overflow)
//   clear_parity   one-clk pulse: clears parity_err
//   clear_framing  one-clk pulse: clears framing_err
//   fifo_full      external receive FIFO is full (RX_FIFO=1)
//   rx_byte        received data; bit7 is 0 in 7-bit mode
//   rx_rdy         byte available (RX_FIFO=0), constant 0 otherwise
//   parity_err     sticky parity error
//   framing_err    sticky framing error (stop bit sampled low)
//   overflow       sticky: byte completed while rx_rdy=1 or fifo_full=1
//   fifo_write_rx  active-low one-clk FIFO write strobe (RX_FIFO=1)

module uart_rx_async #(
  parameter bit RX_FIFO = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       clear_parity,
  input  logic       clear_framing,
  input  logic       fifo_full,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       fifo_write_rx
);

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } state_e;

  // Line synchronizer
  logic       rx_meta_q;
  logic       rx_s_q;

  // Frame recovery
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [1:0] smp_q, smp_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       perr_arm_q, perr_arm_d;

  // Host-visible results
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_rdy_q, rx_rdy_d;
  logic       parity_err_q, parity_err_d;
  logic       framing_err_q, framing_err_d;
  logic       overflow_q, overflow_d;
  logic       fifo_wr_n_q, fifo_wr_n_d;

  logic       bit_maj;
  logic       frame_done;
  logic [2:0] last_idx;
  logic [7:0] new_byte;

  // smp_q holds the samples from counts 7 and 8; rx_s_q is the count-9 sample
  // at the moment the decision is taken.
  assign bit_maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);

  assign last_idx = bit8 ? 3'd7 : 3'd6;

  // Bits enter at the MSB and move toward the LSB, so after only 7 shifts
  // the data sits in [7:1].
  assign new_byte = bit8 ? shift_q : {1'b0, shift_q[7:1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    par_d      = par_q;
    perr_arm_d = perr_arm_q;
    frame_done = 1'b0;

    if (baud_clock) begin
      if (state_q != RX_IDLE) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) smp_d[0] = rx_s_q;
        if (cnt_q == 4'd8) smp_d[1] = rx_s_q;
      end

      case (state_q)
        RX_IDLE: begin
          if (!rx_s_q) begin
            state_d    = START_BIT;
            cnt_d      = 4'd0;
            bit_idx_d  = 3'd0;
            shift_d    = 8'h00;
            par_d      = 1'b0;
            perr_arm_d = 1'b0;
          end
        end

        START_BIT: begin
          if (cnt_q == 4'd9 && bit_maj) begin
            // Start bit did not hold low through its centre: a glitch.
            state_d = RX_IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_q == 4'd15) begin
            state_d = DATA_BITS;
          end
        end

        DATA_BITS: begin
          if (cnt_q == 4'd9) begin
            shift_d = {bit_maj, shift_q[7:1]};
            par_d   = par_q ^ bit_maj;
          end
          if (cnt_q == 4'd15) begin
            if (bit_idx_q == last_idx) begin
              state_d = parity_en ? PARITY_BIT : STOP_BIT;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end

        PARITY_BIT: begin
          if (cnt_q == 4'd9 && (bit_maj != (par_q ^ odd_n_even))) begin
            perr_arm_d = 1'b1;
          end
          if (cnt_q == 4'd15) begin
            state_d = STOP_BIT;
          end
        end

        STOP_BIT: begin
          // Leave at the stop centre rather than its end so that a start
          // edge arriving half a bit later is still seen from idle.
          if (cnt_q == 4'd9) begin
            frame_done = 1'b1;
            state_d    = RX_IDLE;
            cnt_d      = 4'd0;
          end
        end

        default: begin
          state_d = RX_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    rx_byte_d     = rx_byte_q;
    rx_rdy_d      = rx_rdy_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overflow_d    = overflow_q;
    fifo_wr_n_d   = 1'b1;

    // Clears first so that a same-cycle set below takes priority.
    if (read_rx_byte) begin
      rx_rdy_d   = 1'b0;
      overflow_d = 1'b0;
    end
    if (clear_parity)  parity_err_d  = 1'b0;
    if (clear_framing) framing_err_d = 1'b0;

    if (frame_done) begin
      if (!bit_maj)   framing_err_d = 1'b1;
      if (perr_arm_q) parity_err_d  = 1'b1;

      if (RX_FIFO) begin
        rx_byte_d = new_byte;
        if (fifo_full) begin
          overflow_d = 1'b1;
        end else begin
          fifo_wr_n_d = 1'b0;
        end
      end else begin
        // A read in the completion cycle frees the holding register first.
        if (rx_rdy_q && !read_rx_byte) begin
          overflow_d = 1'b1;
        end else begin
          rx_byte_d = new_byte;
          rx_rdy_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= RX_IDLE;
      cnt_q         <= 4'd0;
      bit_idx_q     <= 3'd0;
      smp_q         <= 2'b11;
      shift_q       <= 8'h00;
      par_q         <= 1'b0;
      perr_arm_q    <= 1'b0;
      rx_byte_q     <= 8'h00;
      rx_rdy_q      <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
      fifo_wr_n_q   <= 1'b1;
    end else begin
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      smp_q         <= smp_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      perr_arm_q    <= perr_arm_d;
      rx_byte_q     <= rx_byte_d;
      rx_rdy_q      <= rx_rdy_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
      fifo_wr_n_q   <= fifo_wr_n_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_rdy        = rx_rdy_q;
  assign parity_err    = parity_err_q;
  assign framing_err   = framing_err_q;
  assign overflow      = overflow_q;
  assign fifo_write_rx = fifo_wr_n_q;

endmodule
